// File: rtl/mul_issue_capture.sv
// Registered issue/capture wrapper around a combinational array multiplier.
// Optional feature: MUL_ZERO_BYPASS_EN short-circuits zero operands straight to DONE.
module mul_issue_capture #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   input  logic [WIDTH-1:0] mul_product,
   input  logic             mul_over,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_product,
   output logic             out_over,
   output logic             busy
);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("mul_issue_capture: SETTLE_CYCLES must be 1..255");
   end

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

   state_t           r_state;
   logic [7:0]       r_cnt;
   logic [WIDTH-1:0] r_mul_a;
   logic [WIDTH-1:0] r_mul_b;
   logic [WIDTH-1:0] r_out_product;
   logic             r_out_over;
   logic             r_out_valid;
   logic             w_accept;

   assign w_accept = in_valid && (r_state == S_IDLE);

`ifdef MUL_ZERO_BYPASS_EN
   logic w_zero;
   assign w_zero = (in_a == '0) || (in_b == '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_mul_a       <= '0;
         r_mul_b       <= '0;
         r_out_product <= '0;
         r_out_over    <= 1'b0;
         r_out_valid   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mul_a <= in_a;
                  r_mul_b <= in_b;
`ifdef MUL_ZERO_BYPASS_EN
                  if (w_zero) begin
                     // Product of a zero operand is known; skip the ripple wait.
                     r_out_product <= '0;
                     r_out_over    <= 1'b0;
                     r_out_valid   <= 1'b1;
                     r_state       <= S_DONE;
                  end else begin
                     r_cnt   <= CNT_INIT;
                     r_state <= S_WAIT;
                  end
`else
                  r_cnt   <= CNT_INIT;
                  r_state <= S_WAIT;
`endif
               end
            end
            S_WAIT: begin
               if (r_cnt != 8'd0) begin
                  r_cnt <= r_cnt - 8'd1;
               end else begin
                  r_out_product <= mul_product;
                  r_out_over    <= mul_over;
                  r_out_valid   <= 1'b1;
                  r_state       <= S_DONE;
               end
            end
            S_DONE: begin
               // Non-overlapping: a new pair is only taken once back in IDLE.
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign mul_a       = r_mul_a;
   assign mul_b       = r_mul_b;
   assign out_valid   = r_out_valid;
   assign out_product = r_out_product;
   assign out_over    = r_out_over;

endmodule

// File: tb/tb_mul_issue_capture.sv
// Scoreboard bench for mul_issue_capture: directed vectors, decoupled monitor, latency checks.
module tb_mul_issue_capture;
   localparam int WIDTH  = 32;
   localparam int SETTLE = 4;
`ifdef MUL_ZERO_BYPASS_EN
   localparam int ZLAT = 0;  // result loaded at the handshake edge itself
`else
   localparam int ZLAT = SETTLE;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic [WIDTH-1:0] mul_a, mul_b, mul_product;
   logic             mul_over;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_product;
   logic             out_over;
   logic             busy;
   logic [31:0]      w_hi;

   mul_issue_capture #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b),
      .mul_product(mul_product), .mul_over(mul_over), .out_valid(out_valid),
      .out_ready(out_ready), .out_product(out_product), .out_over(out_over), .busy(busy)
   );

   // Environment stand-in for the combinational multiplier.
   assign {w_hi, mul_product} = 64'(mul_a) * 64'(mul_b);
   assign mul_over = |w_hi;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] p;
      logic        o;
      int          hs;
      int          lat;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops on each rising out_valid, checks stability while held.
   initial begin
      logic        prev_v;
      logic [31:0] held_p;
      logic        held_o;
      exp_t        e;
      prev_v = 1'b0; held_p = '0; held_o = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid && !prev_v) begin
            if (sb.size() == 0) begin
               chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("out_product", 64'(out_product), 64'(e.p));
               chk("out_over", 64'(out_over), 64'(e.o));
               chk("latency", 64'(cyc - e.hs), 64'(e.lat));
            end
         end else if (out_valid && prev_v) begin
            chk("held_product", 64'(out_product), 64'(held_p));
            chk("held_over", 64'(out_over), 64'(held_o));
         end
         prev_v = out_valid;
         held_p = out_product;
         held_o = out_over;
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic o, input int lat);
      exp_t e;
      bit   done;
      done = 0;
      in_a = a; in_b = b; in_valid = 1'b1;
      for (int k = 0; k < 100 && !done; k++) begin
         if (in_ready) begin
            @(posedge clk);
            #1;
            e.p = p; e.o = o; e.hs = cyc; e.lat = lat;
            sb.push_back(e);
            done = 1;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!done) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      bit done;
      done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid && in_ready) done = 1;
      end
      if (!done) chk("drain_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mul_a", 64'(mul_a), 64'd0);
      chk("rst_mul_b", 64'(mul_b), 64'd0);
      chk("rst_out_product", 64'(out_product), 64'd0);
      chk("rst_out_over", 64'(out_over), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // 7*6 with out_ready held high, then in_ready one cycle after the output handshake
      send(32'd7, 32'd6, 32'd42, 1'b0, SETTLE);
      chk("busy_in_wait", 64'(busy), 64'd1);
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      chk("done_in_ready", 64'(in_ready), 64'd0);
      chk("done_mul_a", 64'(mul_a), 64'd7);
      @(negedge clk);
      chk("post_hs_in_ready", 64'(in_ready), 64'd1);
      chk("post_hs_out_valid", 64'(out_valid), 64'd0);
      chk("post_hs_keep_product", 64'(out_product), 64'd42);

      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, SETTLE);
      drain();
      send(32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 1'b0, SETTLE);
      drain();
      send(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, SETTLE);
      drain();
      send(32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0, SETTLE);
      drain();

      // Backpressure on 0x8000_0000*2, second pair offered while held
      out_ready = 1'b0;
      send(32'h8000_0000, 32'd2, 32'd0, 1'b1, SETTLE);
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      in_a = 32'd3; in_b = 32'd5; in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_mul_a", 64'(mul_a), 64'h8000_0000);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_released_out_valid", 64'(out_valid), 64'd0);
      send(32'd3, 32'd5, 32'd15, 1'b0, SETTLE);
      out_ready = 1'b1;
      drain();

      // Zero operands
      send(32'd0, 32'h0000_1234, 32'd0, 1'b0, ZLAT);
      drain();
      send(32'h0000_1234, 32'd0, 32'd0, 1'b0, ZLAT);
      drain();

      // Reset while WAIT has cnt=2
      send(32'd7, 32'd6, 32'd42, 1'b0, SETTLE);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_mul_a", 64'(mul_a), 64'd0);
      chk("mid_rst_out_product", 64'(out_product), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < SETTLE + 4; k++) begin
         @(negedge clk);
         chk("post_rst_in_ready", 64'(in_ready), 64'd1);
         chk("post_rst_out_valid", 64'(out_valid), 64'd0);
      end

      // Normal operation after the mid-flight reset
      send(32'd9, 32'd9, 32'd81, 1'b0, SETTLE);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
